// File: rtl/errvec_pkg.sv
// errvec_collect shared definitions: err_valid codes, FSM states
// and the index/code-length defaults shared with the generator.
package errvec_pkg;

    localparam int IDX_W_DEF   = 13;
    localparam int DEPTH_DEF   = 64;
    localparam int N_LIMIT_DEF = 4900;

    localparam logic [1:0] EV_IDLE  = 2'b00;
    localparam logic [1:0] EV_VALID = 2'b01;
    localparam logic [1:0] EV_CLEAR = 2'b10;
    localparam logic [1:0] EV_DONE  = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_COLLECT = 2'd1;
    localparam state_t ST_DRAIN   = 2'd2;
    localparam state_t ST_DONE    = 2'd3;

endpackage

// File: rtl/errvec_if.sv
// Upstream error-index stream plus downstream drain handshake.
// master = generator/consumer side, slave = errvec_collect.
interface errvec_if
    import errvec_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int DEPTH = DEPTH_DEF
);
    logic [1:0]              err_valid;
    logic [IDX_W-1:0]        err_idx;
    logic [IDX_W-1:0]        out_idx;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;
    logic [$clog2(DEPTH):0]  weight;
    logic                    done;
    logic                    ovf;
    logic                    range_err;

    modport master (
        output err_valid, err_idx, out_ready,
        input  out_idx, out_valid, out_last, weight, done, ovf, range_err
    );

    modport slave (
        input  err_valid, err_idx, out_ready,
        output out_idx, out_valid, out_last, weight, done, ovf, range_err
    );
endinterface

// File: rtl/errvec_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// No reset so it maps onto distributed/block RAM.
module errvec_ram #(
    parameter int DEPTH = 64,
    parameter int W     = 13,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/errvec_collect.sv
// Collects error-vector indices from the syndrome generator and
// replays them in arrival order with the final Hamming weight.
module errvec_collect
    import errvec_pkg::*;
#(
    parameter int IDX_W   = IDX_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int N_LIMIT = N_LIMIT_DEF
) (
    input logic clk,
    input logic rst,
    errvec_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = AW + 1;
    localparam logic [WW-1:0] FULL  = WW'(DEPTH);
    localparam logic [31:0]   LIMIT = 32'(N_LIMIT);

    state_t        state_q, state_d;
    logic [WW-1:0] weight_q, weight_d;
    logic [WW-1:0] rd_q, rd_d;
    logic          last_q, last_d;
    logic          ovf_q, ovf_d;
    logic          rerr_q, rerr_d;
    logic          we, do_clear;
    logic [AW-1:0] raddr;
    logic [WW-1:0] rd_nx;
    logic [IDX_W-1:0] rdata;

    assign rd_nx = rd_q + WW'(1);

    always_comb begin
        state_d  = state_q;
        weight_d = weight_q;
        rd_d     = rd_q;
        last_d   = last_q;
        ovf_d    = ovf_q;
        rerr_d   = rerr_q;
        we       = 1'b0;
        do_clear = 1'b0;
        raddr    = rd_q[AW-1:0];
        unique case (state_q)
            ST_IDLE: do_clear = (bus.err_valid == EV_CLEAR);
            ST_COLLECT: begin
                unique case (bus.err_valid)
                    EV_IDLE: ;
                    EV_VALID: begin
                        if (32'(bus.err_idx) >= LIMIT) begin
                            rerr_d = 1'b1;
                        end else if (weight_q == FULL) begin
                            ovf_d = 1'b1;
                        end else begin
                            we       = 1'b1;
                            weight_d = weight_q + WW'(1);
                        end
                    end
                    EV_CLEAR: do_clear = 1'b1;
                    EV_DONE: begin
                        // prime the read register with entry 0
                        rd_d    = '0;
                        raddr   = '0;
                        last_d  = (weight_q == WW'(1));
                        state_d = (weight_q == '0) ? ST_DONE : ST_DRAIN;
                    end
                endcase
            end
            ST_DRAIN: begin
                if (bus.out_ready) begin
                    if (last_q) begin
                        state_d = ST_DONE;
                        last_d  = 1'b0;
                    end else begin
                        rd_d   = rd_nx;
                        raddr  = rd_nx[AW-1:0];
                        last_d = (rd_q + WW'(2) == weight_q);
                    end
                end
            end
            ST_DONE: do_clear = (bus.err_valid == EV_CLEAR);
        endcase
        if (do_clear) begin
            state_d  = ST_COLLECT;
            weight_d = '0;
            rd_d     = '0;
            last_d   = 1'b0;
            ovf_d    = 1'b0;
            rerr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            weight_q <= '0;
            rd_q     <= '0;
            last_q   <= 1'b0;
            ovf_q    <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            weight_q <= weight_d;
            rd_q     <= rd_d;
            last_q   <= last_d;
            ovf_q    <= ovf_d;
            rerr_q   <= rerr_d;
        end
    end

    errvec_ram #(
        .DEPTH (DEPTH),
        .W     (IDX_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (weight_q[AW-1:0]),
        .wdata_i (bus.err_idx),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    assign bus.out_idx   = rdata;
    assign bus.out_valid = (state_q == ST_DRAIN);
    assign bus.out_last  = last_q;
    assign bus.weight    = weight_q;
    assign bus.done      = (state_q == ST_DONE);
    assign bus.ovf       = ovf_q;
    assign bus.range_err = rerr_q;
endmodule

// File: tb/tb_errvec_collect.sv
// Directed scoreboard bench for errvec_collect.
module tb_errvec_collect;
    import errvec_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;
    logic [12:0] q [$];

    always #5 clk = ~clk;

    errvec_if #(.IDX_W(13), .DEPTH(64)) bus ();

    errvec_collect #(
        .IDX_W   (13),
        .DEPTH   (64),
        .N_LIMIT (4900)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic step(input logic [1:0] ev, input logic [12:0] idx);
        bus.err_valid = ev;
        bus.err_idx   = idx;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [12:0] idx, input bit keep);
        step(EV_VALID, idx);
        if (keep) q.push_back(idx);
    endtask

    // pat=1 drives out_ready 1,0,0,1 repeating; stop<0 drains fully
    task automatic drain(input bit pat, input int stop);
        int n = 0;
        int cyc = 0;
        int gap = 0;
        bit hold = 0;
        logic rdy;
        logic [12:0] held = '0;
        logic [12:0] e;
        bus.err_valid = EV_IDLE;
        while (q.size() > 0 && n != stop && cyc < 300) begin
            rdy = pat ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            bus.out_ready = rdy;
            if (hold) chk("stall_hold", 32'(bus.out_idx), 32'(held));
            if (bus.out_valid && rdy) begin
                e = q.pop_front();
                chk("drain_idx", 32'(bus.out_idx), 32'(e));
                chk("drain_last", 32'(bus.out_last), 32'(q.size() == 0));
                n++;
                hold = 0;
            end else begin
                if (!bus.out_valid) gap++;
                hold = bus.out_valid;
                held = bus.out_idx;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.out_ready = 1'b0;
        chk("drain_budget", 32'(cyc < 300), 32'd1);
        if (!pat && stop < 0) chk("no_gap", 32'(gap), 32'd0);
    endtask

    initial begin
        bus.err_valid = EV_IDLE;
        bus.err_idx   = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        step(EV_IDLE, 0);
        step(EV_IDLE, 0);
        rst = 1'b0;
        chk("rst_weight", 32'(bus.weight), 0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_last", 32'(bus.out_last), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_ovf", 32'(bus.ovf), 0);
        chk("rst_rerr", 32'(bus.range_err), 0);

        // 11 while unarmed must not complete
        for (int i = 0; i < 20; i++) step(EV_DONE, 13'(i));
        chk("idle_done", 32'(bus.done), 0);
        chk("idle_valid", 32'(bus.out_valid), 0);

        // basic vector
        step(EV_CLEAR, 0);
        push(5, 1);
        push(4899, 1);
        push(17, 1);
        chk("basic_weight_pre", 32'(bus.weight), 3);
        step(EV_DONE, 0);
        chk("basic_first_valid", 32'(bus.out_valid), 1);
        drain(0, -1);
        chk("basic_done", 32'(bus.done), 1);
        chk("basic_weight", 32'(bus.weight), 3);
        chk("basic_valid_off", 32'(bus.out_valid), 0);

        // empty vector
        step(EV_CLEAR, 0);
        step(EV_DONE, 0);
        chk("empty_done", 32'(bus.done), 1);
        chk("empty_valid", 32'(bus.out_valid), 0);
        chk("empty_weight", 32'(bus.weight), 0);

        // repeated clear and range drop
        step(EV_CLEAR, 0);
        push(9, 0);
        step(EV_CLEAR, 0);
        chk("reclear_weight", 32'(bus.weight), 0);
        push(100, 1);
        push(4900, 0);
        chk("range_err", 32'(bus.range_err), 1);
        step(EV_DONE, 0);
        drain(0, -1);
        chk("range_weight", 32'(bus.weight), 1);
        chk("range_err_held", 32'(bus.range_err), 1);
        chk("range_done", 32'(bus.done), 1);

        // overflow
        step(EV_CLEAR, 0);
        chk("clr_rerr", 32'(bus.range_err), 0);
        for (int i = 0; i < 64; i++) push(13'(i), 1);
        chk("full_weight", 32'(bus.weight), 64);
        chk("full_no_ovf", 32'(bus.ovf), 0);
        push(64, 0);
        chk("ovf_set", 32'(bus.ovf), 1);
        chk("ovf_weight", 32'(bus.weight), 64);
        for (int i = 65; i < 70; i++) push(13'(i), 0);
        step(EV_DONE, 0);
        drain(0, -1);
        chk("ovf_weight_end", 32'(bus.weight), 64);
        chk("ovf_held", 32'(bus.ovf), 1);

        // stalls and duplicates
        step(EV_CLEAR, 0);
        chk("clr_ovf", 32'(bus.ovf), 0);
        push(7, 1);
        push(7, 1);
        push(8, 1);
        push(4098, 1);
        push(3, 1);
        step(EV_DONE, 0);
        drain(1, -1);
        chk("stall_done", 32'(bus.done), 1);
        chk("stall_weight", 32'(bus.weight), 5);

        // reset in the middle of a drain
        step(EV_CLEAR, 0);
        push(1, 1);
        push(2, 1);
        push(3, 1);
        step(EV_DONE, 0);
        drain(0, 2);
        chk("mid_valid_pre", 32'(bus.out_valid), 1);
        q.delete();
        rst = 1'b1;
        step(EV_IDLE, 0);
        rst = 1'b0;
        chk("mid_rst_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_weight", 32'(bus.weight), 0);
        chk("mid_rst_done", 32'(bus.done), 0);
        for (int i = 0; i < 5; i++) step(EV_DONE, 0);
        chk("rearm_valid", 32'(bus.out_valid), 0);
        chk("rearm_done", 32'(bus.done), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
